// File: rtl/fetch_buffer_unit_if.sv
// Fetch-stage bus: instruction-memory read handshake, decode-facing head port and redirect.
// master = fetch unit side, slave = memory/decode/PC-update side.
interface fetch_buffer_unit_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output mem_req, mem_addr, instr_valid, instr_data, instr_pc,
    input  mem_rvalid, mem_rdata, instr_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, instr_data, instr_pc,
    output mem_rvalid, mem_rdata, instr_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_buffer_unit.sv
// Fetch PC owner + single-outstanding word fetcher feeding a DEPTH-entry {pc,instr} FIFO.
// Optional FETCH_BUFFER_PERF_EN adds perf_fetched / perf_flushed counters.
module fetch_buffer_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                clk,
  input  logic                rst,
  fetch_buffer_unit_if.master bus
`ifdef FETCH_BUFFER_PERF_EN
  ,
  output logic [31:0]         perf_fetched,
  output logic [31:0]         perf_flushed
`endif
);

  localparam int          AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  typedef enum logic [1:0] {FETCH, WAIT, DROP} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  state_e               state_q, state_d;
  logic [31:0]          fetch_pc_q, fetch_pc_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]          count_q, count_d;
  entry_t [DEPTH-1:0]   fifo_q;
  entry_t               head;

  logic redir, rvalid, req, head_vld, push, pop, drop_resp;

  assign redir     = bus.redirect_valid;
  assign rvalid    = bus.mem_rvalid;
  // A slot is reserved at request time, so a push can never find the FIFO full.
  assign req       = rst && (state_q == FETCH) && (count_q != FULL) && !redir;
  assign head_vld  = rst && (count_q != '0);
  assign head      = head_vld ? fifo_q[rd_ptr_q] : '0;
  assign push      = rst && (state_q == WAIT) && rvalid && !redir;
  assign pop       = head_vld && bus.instr_ready && !redir;
  assign drop_resp = rvalid && (((state_q == WAIT) && redir) || (state_q == DROP));

  assign bus.mem_req     = req;
  assign bus.mem_addr    = fetch_pc_q;
  assign bus.instr_valid = head_vld;
  assign bus.instr_data  = head.data;
  assign bus.instr_pc    = head.pc;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redir) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = bus.redirect_pc;
      // DROP with the killed response arriving now has nothing left in flight.
      unique case (state_q)
        WAIT:    state_d = rvalid ? FETCH : DROP;
        DROP:    state_d = rvalid ? FETCH : DROP;
        default: state_d = state_q;
      endcase
    end else begin
      unique case (state_q)
        FETCH: if (req) state_d = WAIT;
        WAIT: if (rvalid) begin
          state_d    = FETCH;
          fetch_pc_d = fetch_pc_q + 32'd1;
        end
        DROP: if (rvalid) state_d = FETCH;
        default: state_d = FETCH;
      endcase
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + ONE;
        2'b01:   count_d = count_q - ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: head outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{pc: fetch_pc_q, data: bus.mem_rdata};
  end

`ifdef FETCH_BUFFER_PERF_EN
  logic [31:0] fetched_q, flushed_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetched_q <= '0;
      flushed_q <= '0;
    end else begin
      fetched_q <= fetched_q + 32'(push);
      flushed_q <= flushed_q + (redir ? 32'(count_q) : 32'd0) + 32'(drop_resp);
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_flushed = flushed_q;
`endif

endmodule

// File: tb/tb_fetch_buffer_unit.sv
// Scoreboard bench for fetch_buffer_unit: directed scenarios push expected requests/instructions,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_fetch_buffer_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_buffer_unit_if bus();
`ifdef FETCH_BUFFER_PERF_EN
  logic [31:0] perf_fetched, perf_flushed;
`endif

  fetch_buffer_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FETCH_BUFFER_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_flushed (perf_flushed)
`endif
  );

  int vectors = 0;
  int errors  = 0;
  logic [31:0] exp_addr[$];
  logic [63:0] exp_instr[$];

  // Memory model: answers the pending request one cycle later while resp_count < resp_limit.
  int          resp_limit  = 0;
  int          resp_count  = 0;
  logic        force_rv    = 1'b0;
  logic [31:0] poison_addr = 32'hFFFF_FFFF;
  logic        pend;
  logic [31:0] paddr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drained(input string nm);
    chk({nm, "_addr_left"}, 64'(exp_addr.size()), 64'd0);
    chk({nm, "_instr_left"}, 64'(exp_instr.size()), 64'd0);
    exp_addr.delete();
    exp_instr.delete();
  endtask

  task automatic enter_reset();
    rst = 1'b0;
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    tick(2);
  endtask

  initial begin
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    pend  = 1'b0;
    paddr = '0;
    forever begin
      @(posedge clk);
      #2;
      if (pend && resp_count < resp_limit) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = (paddr == poison_addr) ? 32'hDEAD : 32'hA0 + paddr;
        resp_count++;
        pend = 1'b0;
      end else begin
        bus.mem_rvalid = force_rv;
      end
      @(negedge clk);
      if (!rst) pend = 1'b0;
      else if (bus.mem_req) begin
        pend  = 1'b1;
        paddr = bus.mem_addr;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.mem_req) begin
          if (exp_addr.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL unexpected_req: got addr %0h, required no request", bus.mem_addr);
          end else chk("mem_addr", {32'h0, bus.mem_addr}, {32'h0, exp_addr.pop_front()});
        end
        if (bus.instr_valid && bus.instr_ready && !bus.redirect_valid) begin
          if (exp_instr.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL unexpected_instr: got pc %0h data %0h, required none",
                     bus.instr_pc, bus.instr_data);
          end else chk("head", {bus.instr_pc, bus.instr_data}, exp_instr.pop_front());
        end
      end
    end
  end

  initial begin
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    // Reset held 3 cycles with a stray rvalid, then first request at RESET_PC
    force_rv = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
      chk("rst_instr_valid", 64'(bus.instr_valid), 64'd0);
      chk("rst_head", {bus.instr_pc, bus.instr_data}, 64'd0);
    end
    @(posedge clk);
    #1;
    force_rv = 1'b0;
    exp_addr.push_back(32'h0);
    rst = 1'b1;
    tick(4);
    @(negedge clk);
    chk("s1_instr_valid", 64'(bus.instr_valid), 64'd0);
    drained("s1");

    // Stream with ready=1
    enter_reset();
    for (int i = 0; i < 4; i++) exp_addr.push_back(32'(i));
    exp_instr.push_back({32'h0, 32'hA0});
    exp_instr.push_back({32'h1, 32'hA1});
    exp_instr.push_back({32'h2, 32'hA2});
    resp_limit = resp_count + 3;
    bus.instr_ready = 1'b1;
    rst = 1'b1;
    tick(14);
    drained("s2");

    // Backpressure: fill 4, no further request, one pop buys exactly one request
    enter_reset();
    for (int i = 0; i < 4; i++) exp_addr.push_back(32'(i));
    resp_limit = resp_count + 5;
    rst = 1'b1;
    tick(12);
    @(negedge clk);
    chk("s3_full_valid", 64'(bus.instr_valid), 64'd1);
    chk("s3_full_head", {bus.instr_pc, bus.instr_data}, {32'h0, 32'hA0});
    exp_instr.push_back({32'h0, 32'hA0});
    exp_addr.push_back(32'h4);
    tick(1);
    bus.instr_ready = 1'b1;
    tick(1);
    bus.instr_ready = 1'b0;
    tick(8);
    @(negedge clk);
    chk("s3_refill_valid", 64'(bus.instr_valid), 64'd1);
    chk("s3_refill_head", {bus.instr_pc, bus.instr_data}, {32'h1, 32'hA1});
    drained("s3");

    // Redirect while waiting on addr 5: its 0xDEAD response must vanish
    enter_reset();
    for (int i = 0; i < 6; i++) exp_addr.push_back(32'(i));
    for (int i = 0; i < 5; i++) exp_instr.push_back({32'(i), 32'hA0 + 32'(i)});
    resp_limit  = resp_count + 5;
    poison_addr = 32'h5;
    bus.instr_ready = 1'b1;
    rst = 1'b1;
    tick(16);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    tick(1);
    bus.redirect_valid = 1'b0;
    exp_addr.push_back(32'h40);
    exp_addr.push_back(32'h41);
    exp_addr.push_back(32'h42);
    exp_instr.push_back({32'h40, 32'hE0});
    exp_instr.push_back({32'h41, 32'hE1});
    resp_limit = resp_count + 3;
    tick(12);
    poison_addr = 32'hFFFF_FFFF;
    drained("s4");

    // Redirect coincident with rvalid and a pop on a near-full FIFO
    enter_reset();
    for (int i = 0; i < 4; i++) exp_addr.push_back(32'(i));
    resp_limit = resp_count + 4;
    rst = 1'b1;
    tick(12);
    @(negedge clk);
    chk("s5_full_valid", 64'(bus.instr_valid), 64'd1);
    exp_instr.push_back({32'h0, 32'hA0});
    exp_addr.push_back(32'h4);
    tick(1);
    bus.instr_ready = 1'b1;
    tick(1);
    bus.instr_ready = 1'b0;
    tick(4);
    exp_addr.push_back(32'h80);
    exp_addr.push_back(32'h81);
    exp_instr.push_back({32'h80, 32'h120});
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h80;
    resp_limit = resp_count + 1;
    tick(1);
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("s5_flushed_valid", 64'(bus.instr_valid), 64'd0);
    resp_limit = resp_count + 1;
    tick(8);
    drained("s5");

    // Redirect on a full FIFO with nothing in flight
    enter_reset();
    for (int i = 0; i < 4; i++) exp_addr.push_back(32'(i));
    resp_limit = resp_count + 4;
    rst = 1'b1;
    tick(12);
    exp_addr.push_back(32'h10);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h10;
    tick(1);
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("s6_flushed_valid", 64'(bus.instr_valid), 64'd0);
`ifdef FETCH_BUFFER_PERF_EN
    chk("perf_fetched", 64'(perf_fetched), 64'd4);
    chk("perf_flushed", 64'(perf_flushed), 64'd4);
`endif
    tick(3);
    drained("s6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
